// File: rtl/output_port_arbiter_pkg.sv
// Shared constants for the per-output-port arbiter: port indices, default size, FSM encoding.
package output_port_arbiter_pkg;

    localparam int N_PORTS_DEF = 5;

    localparam int PORT_LOCAL = 0;
    localparam int PORT_NORTH = 1;
    localparam int PORT_EAST  = 2;
    localparam int PORT_SOUTH = 3;
    localparam int PORT_WEST  = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Width of a port index; at least one bit so a single-port build still elaborates.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/output_port_arbiter_rr_arbiter.sv
// Combinational rotate-priority arbiter: first request at or above ptr wins, wrapping to port 0.
module rr_arbiter
    import output_port_arbiter_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int PTR_W   = ptr_width(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [N_PORTS-1:0] gnt,
    output logic               any
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = ptr;
        for (int k = 0; k < N_PORTS; k++) begin
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                any      = 1'b1;
            end
            idx = (idx == PTR_W'(N_PORTS - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Wormhole output-port arbiter: locks the port to one input until its tail flit transfers,
// then hands priority to the next port in round-robin order.
module output_port_arbiter
    import output_port_arbiter_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PORTS-1:0] req,
    input  logic [N_PORTS-1:0] tail,
    input  logic               ready_in,
    output logic [N_PORTS-1:0] grant,
    output logic [N_PORTS-1:0] ack,
    output logic               buf_enable,
    output logic               busy
);

    localparam int PTR_W = ptr_width(N_PORTS);

    arb_state_e         state_q, state_d;
    logic [N_PORTS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   ptr_q,   ptr_d;

    logic [N_PORTS-1:0] rr_gnt;
    logic               rr_any;
    logic [PTR_W-1:0]   owner_idx;
    logic               tail_xfer;

    rr_arbiter #(
        .N_PORTS (N_PORTS),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req (req),
        .ptr (ptr_q),
        .gnt (rr_gnt),
        .any (rr_any)
    );

    // grant_q is all-zero outside LOCKED, so it alone qualifies the pop; reset suppresses it.
    always_comb begin
        ack = '0;
        if (rst) begin
            ack = grant_q & req & {N_PORTS{ready_in}};
        end
    end

    assign buf_enable = |ack;
    assign tail_xfer  = |(ack & tail);
    assign grant      = grant_q;
    assign busy       = (state_q == ST_LOCKED);

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_q[i]) begin
                owner_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    state_d = ST_LOCKED;
                    grant_d = rr_gnt;
                end else begin
                    grant_d = '0;
                end
            end
            ST_LOCKED: begin
                // Priority moves past the owner only once its whole packet has left.
                if (tail_xfer) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = (owner_idx == PTR_W'(N_PORTS - 1)) ? '0 : owner_idx + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Scoreboard bench: a packet-level reference model predicts grant/ack/busy each cycle,
// and a negedge monitor compares the DUT against the queued predictions.
module tb_output_port_arbiter;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] tail;
    logic         ready_in;
    logic [N-1:0] grant;
    logic [N-1:0] ack;
    logic         buf_enable;
    logic         busy;

    always #5 clk = ~clk;

    output_port_arbiter #(.N_PORTS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .tail       (tail),
        .ready_in   (ready_in),
        .grant      (grant),
        .ack        (ack),
        .buf_enable (buf_enable),
        .busy       (busy)
    );

    typedef struct packed {
        logic [N-1:0] grant;
        logic [N-1:0] ack;
        logic         busy;
        logic         buf_en;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: which port owns the output, and who has priority next.
    bit m_locked;
    int m_owner;
    int m_ptr;
    int flits_left[N];
    bit reload;

    function automatic void model_edge();
        if (!rst) begin
            m_locked = 1'b0;
            m_ptr    = 0;
        end else if (!m_locked) begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (req[p]) begin
                    m_locked = 1'b1;
                    m_owner  = p;
                    break;
                end
            end
        end else if (req[m_owner] && ready_in && tail[m_owner]) begin
            m_locked = 1'b0;
            m_ptr    = (m_owner + 1) % N;
        end
    endfunction

    task automatic step(input bit r, input bit rdy, input logic [N-1:0] bubble);
        exp_t         e;
        logic [N-1:0] rq;
        logic [N-1:0] tl;
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < N; i++) begin
            rq[i] = (flits_left[i] > 0) && !bubble[i];
            tl[i] = (flits_left[i] == 1);
        end
        rst      = r;
        ready_in = rdy;
        req      = rq;
        tail     = tl;
        e.grant  = m_locked ? (N'(1) << m_owner) : '0;
        e.busy   = m_locked;
        e.ack    = '0;
        if (r && m_locked && rq[m_owner] && rdy) begin
            e.ack[m_owner] = 1'b1;
            flits_left[m_owner]--;
            if (reload && flits_left[m_owner] == 0 && $urandom_range(0, 3) != 0) begin
                flits_left[m_owner] = $urandom_range(1, 4);
            end
        end
        e.buf_en = |e.ack;
        sb.push_back(e);
    endtask

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("grant",      32'(grant),      32'(e.grant));
            chk("ack",        32'(ack),        32'(e.ack));
            chk("busy",       32'(busy),       32'(e.busy));
            chk("buf_enable", 32'(buf_enable), 32'(e.buf_en));
        end
    end

    initial begin
        m_locked = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        reload   = 1'b0;
        for (int i = 0; i < N; i++) flits_left[i] = 2;
        rst      = 1'b0;
        ready_in = 1'b1;
        req      = '1;
        tail     = '0;

        // Reset held two edges with every port requesting, then round-robin over 2-flit packets.
        step(1'b0, 1'b1, '0);
        step(1'b1, 1'b1, '0);
        repeat (18) step(1'b1, 1'b1, '0);

        // Single 4-flit packet on the east port.
        flits_left[2] = 4;
        repeat (8) step(1'b1, 1'b1, '0);

        // Backpressure on a 2-flit north packet.
        flits_left[1] = 2;
        step(1'b1, 1'b1, '0);
        step(1'b1, 1'b1, '0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, '0);
        repeat (2) step(1'b1, 1'b1, '0);

        // South holds the lock through a 3-cycle bubble while local waits.
        flits_left[3] = 3;
        step(1'b1, 1'b1, '0);
        step(1'b1, 1'b1, '0);
        flits_left[0] = 1;
        repeat (3) step(1'b1, 1'b1, 5'b01000);
        repeat (6) step(1'b1, 1'b1, '0);

        // Reset in the middle of a 5-flit west packet, then re-arbitrate between west and local.
        flits_left[4] = 5;
        step(1'b1, 1'b1, '0);
        step(1'b1, 1'b1, '0);
        step(1'b1, 1'b1, '0);
        flits_left[0] = 1;
        step(1'b0, 1'b1, '0);
        repeat (8) step(1'b1, 1'b1, '0);

        // Randomised traffic with backpressure, bubbles and occasional reset.
        reload = 1'b1;
        for (int i = 0; i < N; i++) flits_left[i] = $urandom_range(0, 4);
        for (int c = 0; c < 2000; c++) begin
            logic [N-1:0] bub;
            bub = '0;
            for (int i = 0; i < N; i++) bub[i] = ($urandom_range(0, 7) == 0);
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), bub);
            for (int i = 0; i < N; i++) begin
                if (flits_left[i] == 0 && $urandom_range(0, 9) == 0) flits_left[i] = $urandom_range(1, 4);
            end
        end

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
